// File: rtl/regfile_wr_seq_if.sv
// Signal bundle between the write sequencer and its neighbours: request
// handshake, register-file write port, hazard lookup and status.
interface regfile_wr_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [15:0] req_data;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [3:0]  chk_addr;
  logic        chk_hit;
  logic [15:0] chk_data;
  logic        busy;

  modport slave (
    input  req_valid, req_addr, req_data, chk_addr,
    output req_ready, wr_addr, wr_data, wr_en, chk_hit, chk_data, busy
  );

  modport master (
    output req_valid, req_addr, req_data, chk_addr,
    input  req_ready, wr_addr, wr_data, wr_en, chk_hit, chk_data, busy
  );
endinterface

// File: rtl/regfile_wr_seq.sv
// Queues register-file write requests and replays each one as a
// setup / strobe / hold sequence, with a combinational hazard lookup.
module regfile_wr_seq #(
  parameter int DEPTH      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_wr_seq_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [3:0]         wr_addr_q, wr_addr_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               wr_en_q, wr_en_d;

  logic [3:0]         fifo_addr_q [DEPTH];
  logic [15:0]        fifo_data_q [DEPTH];

  logic               req_ready;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               chk_hit;
  logic [15:0]        chk_data;
  logic [PTR_W-1:0]   slot;

  // No pop credit: a full FIFO refuses a request even on the edge it pops.
  assign req_ready  = rst_n && (count_q < (PTR_W+1)'(DEPTH));
  assign push       = bus.req_valid && req_ready;
  assign fifo_empty = (count_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!fifo_empty) begin
          // Chain straight into the next write without an IDLE bubble.
          pop     = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_en_d   = (state_d == ST_STROBE);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_addr_d = fifo_addr_q[rd_ptr_q];
      wr_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.req_addr;
      fifo_data_q[wr_ptr_q] <= bus.req_data;
    end
  end

  // Scan oldest to youngest so the youngest match wins; in-flight is lowest priority.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    slot     = '0;
    if ((state_q != ST_IDLE) && (wr_addr_q == bus.chk_addr)) begin
      chk_hit  = 1'b1;
      chk_data = wr_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (fifo_addr_q[slot] == bus.chk_addr)) begin
        chk_hit  = 1'b1;
        chk_data = fifo_data_q[slot];
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.chk_hit   = chk_hit;
  assign bus.chk_data  = chk_data;
  assign bus.busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_wr_seq.sv
// Directed bench for regfile_wr_seq: default timing (dut_a) and a 2/2/1 variant (dut_b),
// with a scoreboard of accepted requests checked against each wr_en pulse.
module tb_regfile_wr_seq;
  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  regfile_wr_seq_if ia();
  regfile_wr_seq_if ib();

  regfile_wr_seq #(.DEPTH(4), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(ia.slave));
  regfile_wr_seq #(.DEPTH(4), .SETUP_CYC(2), .STROBE_CYC(2), .HOLD_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(ib.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] sb_a[$];
  logic [19:0] sb_b[$];
  int          rises_a[$];
  int          rises_b[$];
  int          writes_a = 0;
  int          writes_b = 0;
  logic        pa = 1'b0;
  logic        pb = 1'b0;
  int          wa = 0;
  int          wb = 0;
  logic [19:0] exp_wa;
  logic [19:0] exp_wb;
  bit          saw_full_a = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h required=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard push on acceptance; a reset discards everything queued.
  always @(posedge clk) begin
    if (rst_n_a !== 1'b1) sb_a.delete();
    else if (ia.req_valid && ia.req_ready) sb_a.push_back({ia.req_addr, ia.req_data});
    if (rst_n_b !== 1'b1) sb_b.delete();
    else if (ib.req_valid && ib.req_ready) sb_b.push_back({ib.req_addr, ib.req_data});
  end

  always @(negedge clk) begin
    if (ia.wr_en === 1'b1 && pa !== 1'b1) begin
      writes_a++;
      rises_a.push_back(cyc);
      chk("write_expected_a", (sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        exp_wa = sb_a.pop_front();
        chk("write_order_a", {ia.wr_addr, ia.wr_data}, exp_wa);
      end
    end
    if (ia.wr_en === 1'b1) wa++;
    else begin
      if (pa === 1'b1 && rst_n_a === 1'b1) chk("strobe_width_a", wa, 1);
      wa = 0;
    end
    pa = ia.wr_en;

    if (ib.wr_en === 1'b1 && pb !== 1'b1) begin
      writes_b++;
      rises_b.push_back(cyc);
      chk("write_expected_b", (sb_b.size() != 0), 1);
      if (sb_b.size() != 0) begin
        exp_wb = sb_b.pop_front();
        chk("write_order_b", {ib.wr_addr, ib.wr_data}, exp_wb);
      end
    end
    if (ib.wr_en === 1'b1) wb++;
    else begin
      if (pb === 1'b1 && rst_n_b === 1'b1) chk("strobe_width_b", wb, 2);
      wb = 0;
    end
    pb = ib.wr_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? ib.req_ready : ia.req_ready;
  endfunction

  function automatic logic bsy(input bit sel);
    return sel ? ib.busy : ia.busy;
  endfunction

  task automatic send(input bit sel, input logic [3:0] a, input logic [15:0] d);
    int n;
    n = 0;
    if (sel) begin ib.req_valid = 1'b1; ib.req_addr = a; ib.req_data = d; end
    else     begin ia.req_valid = 1'b1; ia.req_addr = a; ia.req_data = d; end
    if (!sel && rdy(sel) !== 1'b1) saw_full_a = 1'b1;
    while (rdy(sel) !== 1'b1 && n < 50) begin tick(); n++; end
    chk(sel ? "ready_timeout_b" : "ready_timeout_a", (n < 50), 1);
    tick();
  endtask

  task automatic wait_idle(input bit sel, input int max);
    int n;
    n = 0;
    while (bsy(sel) !== 1'b0 && n < max) begin tick(); n++; end
    chk(sel ? "idle_timeout_b" : "idle_timeout_a", (n < max), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    int snap;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    ia.req_valid = 1'b0; ia.req_addr = '0; ia.req_data = '0; ia.chk_addr = '0;
    ib.req_valid = 1'b0; ib.req_addr = '0; ib.req_data = '0; ib.chk_addr = '0;
    tick(); tick();

    // Reset state.
    chk("rst_ready_a", ia.req_ready, 0);
    chk("rst_wr_en_a", ia.wr_en, 0);
    chk("rst_wr_addr_a", ia.wr_addr, 0);
    chk("rst_wr_data_a", ia.wr_data, 0);
    chk("rst_busy_a", ia.busy, 0);
    chk("rst_chk_hit_a", ia.chk_hit, 0);
    chk("rst_chk_data_a", ia.chk_data, 0);
    chk("rst_ready_b", ib.req_ready, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    tick();
    chk("post_rst_ready_a", ia.req_ready, 1);
    chk("post_rst_busy_a", ia.busy, 0);
    chk("post_rst_ready_b", ib.req_ready, 1);

    // Single write, default timing.
    ia.chk_addr = 4'd3;
    ia.req_valid = 1'b1; ia.req_addr = 4'd3; ia.req_data = 16'h1234;
    tick();
    ia.req_valid = 1'b0;
    chk("t0_busy", ia.busy, 1);
    chk("t0_chk_hit", ia.chk_hit, 1);
    chk("t0_chk_data", ia.chk_data, 16'h1234);
    chk("t0_wr_en", ia.wr_en, 0);
    tick();
    chk("t1_wr_addr", ia.wr_addr, 3);
    chk("t1_wr_data", ia.wr_data, 16'h1234);
    chk("t1_wr_en", ia.wr_en, 0);
    tick();
    chk("t2_wr_en", ia.wr_en, 1);
    tick();
    chk("t3_wr_en", ia.wr_en, 0);
    chk("t3_inflight_hit", ia.chk_hit, 1);
    chk("t3_inflight_data", ia.chk_data, 16'h1234);
    tick();
    chk("t4_wr_en", ia.wr_en, 0);
    chk("t4_wr_addr", ia.wr_addr, 3);
    chk("t4_wr_data", ia.wr_data, 16'h1234);
    chk("t4_busy", ia.busy, 0);
    chk("t4_chk_hit", ia.chk_hit, 0);
    chk("t4_chk_data", ia.chk_data, 0);

    // Hazard lookup: youngest pending write to the same address wins.
    ia.chk_addr = 4'd5;
    send(0, 4'd5, 16'h00A0);
    send(0, 4'd5, 16'h00B0);
    chk("haz2_hit", ia.chk_hit, 1);
    chk("haz2_data", ia.chk_data, 16'h00B0);
    send(0, 4'd5, 16'h00C0);
    ia.req_valid = 1'b0;
    chk("haz3_hit", ia.chk_hit, 1);
    chk("haz3_data", ia.chk_data, 16'h00C0);
    ia.chk_addr = 4'd6;
    #1;
    chk("haz_miss_hit", ia.chk_hit, 0);
    chk("haz_miss_data", ia.chk_data, 0);
    ia.chk_addr = 4'd5;
    wait_idle(0, 50);
    chk("haz_done_hit", ia.chk_hit, 0);
    chk("haz_done_data", ia.chk_data, 0);
    chk("haz_writes", writes_a, 4);

    // Fill and pointer wrap: 10 back-to-back requests.
    n0 = rises_a.size();
    for (int i = 0; i < 10; i++) send(0, 4'(i), 16'(i * 32'h2408));
    ia.req_valid = 1'b0;
    chk("fill_ready_low_seen", saw_full_a, 1);
    wait_idle(0, 100);
    chk("fill_sb_empty", sb_a.size(), 0);
    chk("fill_writes", rises_a.size() - n0, 10);
    for (int k = n0 + 1; k < rises_a.size(); k++)
      chk("spacing_a", rises_a[k] - rises_a[k-1], 3);

    // Variant timing 2/2/1: latency and strobe width.
    ib.req_valid = 1'b1; ib.req_addr = 4'd9; ib.req_data = 16'hBEEF;
    tick();
    ib.req_valid = 1'b0;
    tick();
    chk("b_t1_wr_addr", ib.wr_addr, 9);
    chk("b_t1_wr_en", ib.wr_en, 0);
    tick();
    chk("b_t2_wr_en", ib.wr_en, 0);
    tick();
    chk("b_t3_wr_en", ib.wr_en, 1);
    tick();
    chk("b_t4_wr_en", ib.wr_en, 1);
    tick();
    chk("b_t5_wr_en", ib.wr_en, 0);
    tick();
    chk("b_t6_busy", ib.busy, 0);

    n0 = rises_b.size();
    for (int i = 0; i < 4; i++) send(1, 4'(10 + i), 16'(32'h1000 + i));
    ib.req_valid = 1'b0;
    wait_idle(1, 100);
    chk("b_writes", rises_b.size() - n0, 4);
    for (int k = n0 + 1; k < rises_b.size(); k++)
      chk("spacing_b", rises_b[k] - rises_b[k-1], 5);

    // Reset in the middle of a strobe with two writes still queued.
    ib.chk_addr = 4'd2;
    send(1, 4'd1, 16'h0011);
    send(1, 4'd2, 16'h0022);
    send(1, 4'd3, 16'h0033);
    ib.req_valid = 1'b0;
    n = 0;
    while (ib.wr_en !== 1'b1 && n < 20) begin tick(); n++; end
    chk("b_strobe_timeout", (n < 20), 1);
    chk("b_pre_rst_busy", ib.busy, 1);
    rst_n_b = 1'b0;
    tick();
    chk("b_rst_wr_en", ib.wr_en, 0);
    chk("b_rst_busy", ib.busy, 0);
    chk("b_rst_ready", ib.req_ready, 0);
    chk("b_rst_wr_addr", ib.wr_addr, 0);
    tick();
    rst_n_b = 1'b1;
    snap = writes_b;
    tick();
    chk("b_rel_ready", ib.req_ready, 1);
    chk("b_rel_busy", ib.busy, 0);
    chk("b_rel_chk_hit", ib.chk_hit, 0);
    chk("b_rel_chk_data", ib.chk_data, 0);
    repeat (10) tick();
    chk("b_no_writes_after_rst", writes_b - snap, 0);
    chk("b_final_busy", ib.busy, 0);

    chk("final_sb_a", sb_a.size(), 0);
    chk("final_sb_b", sb_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
